// File: rtl/cursor_position_ctrl_if.sv
// Draw-request handshake between the cursor controller and the canvas writer.
interface cursor_position_ctrl_if;
    logic       draw_valid_out;
    logic       draw_ready_in;
    logic [9:0] draw_x_out;
    logic [8:0] draw_y_out;

    modport master (output draw_valid_out, draw_x_out, draw_y_out, input draw_ready_in);
    modport slave  (input draw_valid_out, draw_x_out, draw_y_out, output draw_ready_in);
endinterface

// File: rtl/cursor_position_ctrl.sv
// Cursor position controller: frame-gated position commit, stroke width/type, draw requests.
// Optional macro CURSOR_WRAP_EN: wrap coordinates modulo the canvas size instead of clamping.
module cursor_position_ctrl #(
    parameter int CANVAS_W    = 320,
    parameter int CANVAS_H    = 240,
    parameter int X_INIT      = 160,
    parameter int Y_INIT      = 120,
    parameter int SPEED_SHIFT = 0
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       new_frame_in,
    input  logic       delta_valid_in,
    input  logic [8:0] dx_in,
    input  logic [8:0] dy_in,
    input  logic       pen_down_in,
    input  logic       width_up_in,
    input  logic       width_down_in,
    input  logic       type_toggle_in,
    output logic [9:0] x_out,
    output logic [8:0] y_out,
    output logic [2:0] stroke_width_out,
    output logic       cursor_type_out,
    output logic       overrun_out,
    cursor_position_ctrl_if.master draw
);
    localparam logic signed [12:0] W13   = 13'(CANVAS_W);
    localparam logic signed [12:0] H13   = 13'(CANVAS_H);
    localparam logic signed [12:0] XMAX  = 13'(CANVAS_W - 1);
    localparam logic signed [12:0] YMAX  = 13'(CANVAS_H - 1);
`ifdef CURSOR_WRAP_EN
    // Keeps |acc| below one canvas span so a single modulo step is enough.
    localparam logic signed [12:0] AX_HI = XMAX;
    localparam logic signed [12:0] AX_LO = -XMAX;
    localparam logic signed [12:0] AY_HI = YMAX;
    localparam logic signed [12:0] AY_LO = -YMAX;
`else
    localparam logic signed [12:0] AX_HI = 13'sd2047;
    localparam logic signed [12:0] AX_LO = -13'sd2048;
    localparam logic signed [12:0] AY_HI = 13'sd2047;
    localparam logic signed [12:0] AY_LO = -13'sd2048;
`endif

    typedef enum logic {IDLE, REQ} state_t;

    state_t             state, state_nxt;
    logic signed [11:0] acc_x, acc_y, acc_x_nxt, acc_y_nxt;
    logic signed [11:0] dx_ext, dy_ext, base_x, base_y;
    logic signed [12:0] sum_x, sum_y, nx_raw, ny_raw, nx, ny;
    logic               commit_req, load, ov_set;

    function automatic logic signed [11:0] limit(input logic signed [12:0] s,
                                                 input logic signed [12:0] lo,
                                                 input logic signed [12:0] hi);
        logic signed [12:0] r;
        r = s;
        if (s > hi)      r = hi;
        else if (s < lo) r = lo;
        return r[11:0];
    endfunction

    assign dx_ext = 12'($signed(dx_in)) <<< SPEED_SHIFT;
    assign dy_ext = 12'($signed(dy_in)) <<< SPEED_SHIFT;

    // A commit consumes the old accumulator; a same-cycle delta starts the next frame.
    assign base_x = new_frame_in ? 12'sd0 : acc_x;
    assign base_y = new_frame_in ? 12'sd0 : acc_y;
    assign sum_x  = $signed({base_x[11], base_x}) + $signed({dx_ext[11], dx_ext});
    assign sum_y  = $signed({base_y[11], base_y}) + $signed({dy_ext[11], dy_ext});
    assign acc_x_nxt = delta_valid_in ? limit(sum_x, AX_LO, AX_HI) : base_x;
    assign acc_y_nxt = delta_valid_in ? limit(sum_y, AY_LO, AY_HI) : base_y;

    assign nx_raw = $signed({3'b000, x_out}) + $signed({acc_x[11], acc_x});
    assign ny_raw = $signed({4'b0000, y_out}) + $signed({acc_y[11], acc_y});

    always_comb begin
        nx = nx_raw;
        ny = ny_raw;
`ifdef CURSOR_WRAP_EN
        if (nx_raw < 0)          nx = nx_raw + W13;
        else if (nx_raw >= W13)  nx = nx_raw - W13;
        if (ny_raw < 0)          ny = ny_raw + H13;
        else if (ny_raw >= H13)  ny = ny_raw - H13;
`else
        if (nx_raw < 0)          nx = 13'sd0;
        else if (nx_raw > XMAX)  nx = XMAX;
        if (ny_raw < 0)          ny = 13'sd0;
        else if (ny_raw > YMAX)  ny = YMAX;
`endif
    end

    assign commit_req = new_frame_in & pen_down_in;

    always_comb begin
        state_nxt           = state;
        load                = 1'b0;
        ov_set              = 1'b0;
        draw.draw_valid_out = (state == REQ);
        case (state)
            IDLE: if (commit_req) begin
                load      = 1'b1;
                state_nxt = REQ;
            end
            REQ: begin
                // Handshake frees the slot, so a coincident commit reloads instead of overrunning.
                if (draw.draw_ready_in) begin
                    if (commit_req) load = 1'b1;
                    else            state_nxt = IDLE;
                end else if (commit_req) begin
                    ov_set = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= IDLE;
            acc_x            <= '0;
            acc_y            <= '0;
            x_out            <= 10'(X_INIT);
            y_out            <= 9'(Y_INIT);
            stroke_width_out <= '0;
            cursor_type_out  <= 1'b1;
            overrun_out      <= 1'b0;
            draw.draw_x_out  <= '0;
            draw.draw_y_out  <= '0;
        end else begin
            state <= state_nxt;
            acc_x <= acc_x_nxt;
            acc_y <= acc_y_nxt;
            if (new_frame_in) begin
                x_out <= nx[9:0];
                y_out <= ny[8:0];
            end
            if (load) begin
                draw.draw_x_out <= nx[9:0];
                draw.draw_y_out <= ny[8:0];
            end
            if (ov_set) overrun_out <= 1'b1;
            if (width_up_in && !width_down_in && stroke_width_out != 3'd7)
                stroke_width_out <= stroke_width_out + 3'd1;
            else if (width_down_in && !width_up_in && stroke_width_out != 3'd0)
                stroke_width_out <= stroke_width_out - 3'd1;
            if (type_toggle_in) cursor_type_out <= ~cursor_type_out;
        end
    end
endmodule
